mux_scan_pipe: RTL and testbench

Parametrised, pipelined N:1 word multiplexer built as a tree of 4:1 stages, with a registered stage per tree level and a valid bit that travels with each selection. It is the next generation of our 16:1 bit mux: it handles multi-bit channels, any power-of-two channel count, a stall input, and an optional auto-scan mode that sweeps all channels. It sits between a bank of channel sources (sensor or register taps) and a single serial consumer.

---
 rtl/mux_scan_pipe.sv | 146 ++++++++++++++
 tb/tb_mux_scan_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_pipe.sv
// rtl/mux_scan_pipe.sv - pipelined N:1 word mux tree of 4:1 stages; optional auto-scan via MUX_SCAN_EN
module mux_scan_pipe #(
    parameter int WIDTH = 8,
    parameter int CH = 16,
    localparam int SELW = $clog2(CH),
    localparam int LAT = (SELW + 1) / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   i,
    input  logic [SELW-1:0]       s,
    input  logic                  sel_valid,
    input  logic                  mode,
    input  logic                  en,
    output logic [WIDTH-1:0]      y,
    output logic [SELW-1:0]       y_ch,
    output logic                  y_valid
);

    logic [SELW-1:0] issue_ch;
    logic            issue_v;

`ifdef MUX_SCAN_EN
    logic [SELW-1:0] scan_cnt;

    // Scan counter: sweeps channels while scanning, parked at 0 in direct mode, frozen on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (en) begin
            if (mode) begin
                scan_cnt <= scan_cnt + 1'b1;
            end else begin
                scan_cnt <= '0;
            end
        end
    end

    // Issue source: scan counter overrides the direct select while scanning
    always_comb begin
        issue_ch = s;
        issue_v  = sel_valid;
        if (mode) begin
            issue_ch = scan_cnt;
            issue_v  = 1'b1;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    // Issue source: direct select only
    always_comb begin
        issue_ch = s;
        issue_v  = sel_valid;
    end
`endif

    for (genvar n = 0; n < LAT; n++) begin : g_lvl
        localparam int NIN  = CH >> (2 * n);
        localparam bit LAST = (n == LAT - 1);
        localparam bit TWO  = LAST && (SELW % 2 == 1);
        localparam int NOUT = TWO ? NIN / 2 : NIN / 4;

        logic [WIDTH-1:0] in_w [NIN];
        logic [WIDTH-1:0] nxt  [NOUT];
        logic [WIDTH-1:0] q    [NOUT];
        logic [SELW-1:0]  ch_in;
        logic [SELW-1:0]  ch_q;
        logic             v_in;
        logic             v_q;

        if (n == 0) begin : g_src
            // Only the first level looks at the channel bus
            for (genvar k = 0; k < NIN; k++) begin : g_ch
                assign in_w[k] = i[k*WIDTH +: WIDTH];
            end
            assign ch_in = issue_ch;
            assign v_in  = issue_v;
        end else begin : g_src
            for (genvar k = 0; k < NIN; k++) begin : g_ch
                assign in_w[k] = g_lvl[n-1].q[k];
            end
            assign ch_in = g_lvl[n-1].ch_q;
            assign v_in  = g_lvl[n-1].v_q;
        end

        if (TWO) begin : g_mux
            // Odd select width: final level is 2:1 on the top select bit
            for (genvar k = 0; k < NOUT; k++) begin : g_grp
                assign nxt[k] = ch_in[2*n] ? in_w[2*k+1] : in_w[2*k];
            end
        end else begin : g_mux
            for (genvar k = 0; k < NOUT; k++) begin : g_grp
                // 4:1 pick within each group using this level's select pair
                always_comb begin
                    case (ch_in[2*n+1:2*n])
                        2'd0:    nxt[k] = in_w[4*k];
                        2'd1:    nxt[k] = in_w[4*k+1];
                        2'd2:    nxt[k] = in_w[4*k+2];
                        default: nxt[k] = in_w[4*k+3];
                    endcase
                end
            end
        end

        if (LAST) begin : g_reg
            // Output level: valid tracks every enabled edge, data/index only load on a real selection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q[0] <= '0;
                    ch_q <= '0;
                    v_q  <= 1'b0;
                end else if (en) begin
                    v_q <= v_in;
                    if (v_in) begin
                        q[0] <= nxt[0];
                        ch_q <= ch_in;
                    end
                end
            end
        end else begin : g_reg
            // Inner level: partial results, index and valid advance together
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < NOUT; k++) begin
                        q[k] <= '0;
                    end
                    ch_q <= '0;
                    v_q  <= 1'b0;
                end else if (en) begin
                    for (int k = 0; k < NOUT; k++) begin
                        q[k] <= nxt[k];
                    end
                    ch_q <= ch_in;
                    v_q  <= v_in;
                end
            end
        end
    end

    assign y       = g_lvl[LAT-1].q[0];
    assign y_ch    = g_lvl[LAT-1].ch_q;
    assign y_valid = g_lvl[LAT-1].v_q;

endmodule

// File: tb/tb_mux_scan_pipe.sv
// tb/tb_mux_scan_pipe.sv - self-checking bench for mux_scan_pipe
module tb_mux_scan_pipe;

    localparam int WIDTH = 8;
    localparam int CH    = 16;
    localparam int SELW  = 4;
    localparam int LAT   = 2;
`ifdef MUX_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [CH*WIDTH-1:0] i;
    logic [SELW-1:0]     s;
    logic                sel_valid;
    logic                mode;
    logic                en;
    logic [WIDTH-1:0]    y;
    logic [SELW-1:0]     y_ch;
    logic                y_valid;

    logic [31:0]         i8;
    logic [2:0]          s8;
    logic                sv8;
    logic [3:0]          y8;
    logic [2:0]          ych8;
    logic                yv8;

    always #5 clk = ~clk;

    mux_scan_pipe #(.WIDTH(WIDTH), .CH(CH)) dut (
        .clk(clk), .rst(rst), .i(i), .s(s), .sel_valid(sel_valid), .mode(mode),
        .en(en), .y(y), .y_ch(y_ch), .y_valid(y_valid)
    );

    mux_scan_pipe #(.WIDTH(4), .CH(8)) dut8 (
        .clk(clk), .rst(rst), .i(i8), .s(s8), .sel_valid(sv8), .mode(1'b0),
        .en(en), .y(y8), .y_ch(ych8), .y_valid(yv8)
    );

    typedef struct packed {
        logic            v;
        logic [SELW-1:0] ch;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t             sbq[$];
    logic [WIDTH-1:0] exp_y;
    logic [SELW-1:0]  exp_ch;
    logic             exp_v;
    logic [SELW-1:0]  tb_scan;
    int               passed = 0;
    int               failed = 0;
    int               total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_pattern(input logic [7:0] base);
        for (int k = 0; k < CH; k++) begin
            i[k*WIDTH +: WIDTH] = base + 8'(k);
        end
    endtask

    task automatic model_clear();
        sbq.delete();
        exp_y   = '0;
        exp_ch  = '0;
        exp_v   = 1'b0;
        tb_scan = '0;
    endtask

    task automatic step(input string tag, input logic e, input logic sv,
                        input logic [SELW-1:0] sel, input logic m);
        ent_t n;
        ent_t o;
        en        = e;
        sel_valid = sv;
        s         = sel;
        mode      = m;
        if (m && SCAN) begin
            n.v  = 1'b1;
            n.ch = tb_scan;
        end else begin
            n.v  = sv;
            n.ch = sel;
        end
        n.d = i[n.ch*WIDTH +: WIDTH];
        @(posedge clk);
        #1;
        if (e) begin
            tb_scan = m ? tb_scan + 1'b1 : '0;
            sbq.push_back(n);
            if (sbq.size() == LAT) begin
                o     = sbq.pop_front();
                exp_v = o.v;
                if (o.v) begin
                    exp_y  = o.d;
                    exp_ch = o.ch;
                end
            end
        end
        check({tag, ".y_valid"}, 32'(y_valid), 32'(exp_v));
        check({tag, ".y"}, 32'(y), 32'(exp_y));
        check({tag, ".y_ch"}, 32'(y_ch), 32'(exp_ch));
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        sel_valid = 1'b0;
        s         = '0;
        mode      = 1'b0;
        sv8       = 1'b0;
        s8        = '0;
        for (int k = 0; k < 8; k++) begin
            i8[k*4 +: 4] = 4'(k);
        end
        set_pattern(8'h10);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset.y", 32'(y), 32'h0);
        check("reset.y_ch", 32'(y_ch), 32'h0);
        check("reset.y_valid", 32'(y_valid), 32'h0);
        rst = 1'b0;

        // direct select of channel 9
        step("direct9_issue", 1'b1, 1'b1, 4'd9, 1'b0);
        step("direct9_out", 1'b1, 1'b0, 4'd0, 1'b0);
        check("direct9.y_lit", 32'(y), 32'h19);
        step("direct9_after", 1'b1, 1'b0, 4'd0, 1'b0);
        check("direct9.pulse_once", 32'(y_valid), 32'h0);

        // back-to-back issues, then change the channel bus
        step("b2b_0", 1'b1, 1'b1, 4'd0, 1'b0);
        step("b2b_15", 1'b1, 1'b1, 4'd15, 1'b0);
        step("b2b_5", 1'b1, 1'b1, 4'd5, 1'b0);
        step("b2b_10", 1'b1, 1'b1, 4'd10, 1'b0);
        set_pattern(8'hA0);
        step("b2b_d1", 1'b1, 1'b0, 4'd0, 1'b0);
        check("b2b.last_lit", 32'(y), 32'h1A);
        step("b2b_d2", 1'b1, 1'b0, 4'd0, 1'b0);
        set_pattern(8'h10);

        // stall with a stray select that must be ignored
        step("stall_issue", 1'b1, 1'b1, 4'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step("stall_hold", 1'b0, 1'b1, 4'd5, 1'b0);
        end
        step("stall_resume", 1'b1, 1'b0, 4'd0, 1'b0);
        check("stall.y_lit", 32'(y), 32'h13);
        step("stall_drain", 1'b1, 1'b0, 4'd0, 1'b0);

        // auto-scan for 20 enabled cycles, then back to direct
        for (int k = 0; k < 20; k++) begin
            step("scan", 1'b1, 1'b0, 4'd0, 1'b1);
        end
        step("scan_exit_issue12", 1'b1, 1'b1, 4'd12, 1'b0);
        step("scan_exit_d1", 1'b1, 1'b0, 4'd0, 1'b0);
        step("scan_exit_d2", 1'b1, 1'b0, 4'd0, 1'b0);

        // reset in flight
        step("rst_issue7", 1'b1, 1'b1, 4'd7, 1'b0);
        sel_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async.y", 32'(y), 32'h0);
        check("rst_async.y_ch", 32'(y_ch), 32'h0);
        check("rst_async.y_valid", 32'(y_valid), 32'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("rst_after", 1'b1, 1'b0, 4'd0, 1'b0);
        end

        // odd select width instance: 8 channels of 4 bits
        sv8 = 1'b1;
        s8  = 3'd6;
        @(posedge clk);
        #1;
        sv8 = 1'b0;
        check("odd.lat1_valid", 32'(yv8), 32'h0);
        @(posedge clk);
        #1;
        check("odd.y_valid", 32'(yv8), 32'h1);
        check("odd.y", 32'(y8), 32'h6);
        check("odd.y_ch", 32'(ych8), 32'h6);
        @(posedge clk);
        #1;
        check("odd.pulse_once", 32'(yv8), 32'h0);
        check("odd.hold", 32'(y8), 32'h6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
